// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone word memory with a 2-deep in-order request queue; WB_MEM_ERR_EN adds wb_err_o for out-of-range addresses.
// Latency: ack/err is high in the cycle after edge k+WAIT_CYCLES for a request accepted at edge k into an idle slave.
// Backpressure: wb_stall_o rises when both queue slots are occupied; dropping wb_cyc_i flushes all pending work.

module wb_mem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push && !flush) slots[wr_ptr] <= push_dat;
  end

  assign head_dat = slots[rd_ptr];

endmodule

module wb_mem_slave #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o
`ifdef WB_MEM_ERR_EN
  ,
  output logic        wb_err_o
`endif
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef struct packed {
    logic            oor;
    logic            we;
    logic [3:0]      sel;
    logic [31:0]     dat;
    logic [IDXW-1:0] idx;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  req_t        req_in;
  req_t        head;
  logic [1:0]  q_count;
  logic        push;
  logic        pop;
  logic        pending;
  logic        mem_wr;
  logic        resp_err;
  logic [31:0] mem [DEPTH_WORDS];

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[1:0], wb_adr_i[31:IDXW+2]};

  assign wb_stall_o = (q_count == 2'd2);
  assign push       = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign pop        = (state == S_RESPOND);

  always_comb begin
    req_in     = '0;
    req_in.idx = wb_adr_i[IDXW+1:2];
    req_in.dat = wb_dat_i;
    req_in.we  = wb_we_i;
    req_in.sel = wb_sel_i;
`ifdef WB_MEM_ERR_EN
    req_in.oor = |wb_adr_i[31:IDXW+2];
`else
    req_in.oor = 1'b0;
`endif
  end

  wb_mem_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (2)
  ) u_queue (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush    (~wb_cyc_i),
    .push     (push),
    .push_dat (req_in),
    .pop      (pop),
    .head_dat (head),
    .count    (q_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (!wb_cyc_i)
        wait_cnt <= 4'd0;
      else if (state_nxt == S_WAIT && state != S_WAIT)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Work remains after this edge if something is pushed or an entry survives the pop.
  always_comb begin
    pending   = push | (pop ? (q_count == 2'd2) : (q_count != 2'd0));
    state_nxt = state;
    case (state)
      S_IDLE:    if (pending) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESPOND;
      S_WAIT:    if (wait_cnt == 4'd0) state_nxt = S_RESPOND;
      S_RESPOND: state_nxt = pending ? ((WAIT_CYCLES > 0) ? S_WAIT : S_RESPOND) : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (!wb_cyc_i) state_nxt = S_IDLE;
  end

  always_comb begin
    wb_ack_o = 1'b0;
    resp_err = 1'b0;
    wb_dat_o = '0;
    mem_wr   = 1'b0;
    if (state == S_RESPOND) begin
      if (head.oor) begin
        resp_err = 1'b1;
      end else begin
        wb_ack_o = 1'b1;
        if (head.we) mem_wr = wb_cyc_i;
        else         wb_dat_o = mem[head.idx];
      end
    end
  end

`ifdef WB_MEM_ERR_EN
  assign wb_err_o = resp_err;
`else
  logic unused_err;
  assign unused_err = resp_err;
`endif

  // Contents are deliberately left unreset so they survive resets and bus cycles.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head.sel[b]) mem[head.idx][8*b +: 8] <= head.dat[8*b +: 8];
      end
    end
  end

endmodule
